// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: widths, opcodes,
// FSM encoding and the reference ALU function.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD   = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB   = 2'b01;
  localparam logic [OP_W-1:0] OP_AND   = 2'b10;
  localparam logic [OP_W-1:0] OP_PASSA = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Modulo-2^DATA_W arithmetic; carry and borrow are dropped.
  function automatic logic [DATA_W-1:0] alu_eval(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [OP_W-1:0]   op);
    logic [DATA_W-1:0] y;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      default: y = a;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the shared-ALU arbiter.
// Requester i uses slice [i*DATA_W +: DATA_W] of req_a/req_b and [i*OP_W +: OP_W] of req_op.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic [2*OP_W-1:0]   req_op;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_zero;
  logic                busy;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, busy
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Shared 4-bit ALU; output is forced to zero whenever it is not enabled.
module lab2_ALU
  import alu_pkg::*;
(
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] y_o
);

  assign y_o = en_i ? alu_eval(a_i, b_i, op_i) : '0;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one lab2_ALU between two requesters: accept in
// IDLE, compute in EXEC, hold the result in RESP until the owner takes it.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  state_e            state_q;
  logic              owner_q;
  logic              last_grant_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [OP_W-1:0]   op_code_q;
  logic [DATA_W-1:0] result_q;
  logic              rsp_zero_q;
  logic [1:0]        rsp_valid_q;
  logic              busy_q;

  logic              grant_vld;
  logic              grant_idx;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;
  logic              alu_en;
  logic [DATA_W-1:0] alu_y;

  // On contention the requester that did not win last time is served.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    case (bus.req_valid)
      2'b01: begin grant_vld = 1'b1; grant_idx = 1'b0;          end
      2'b10: begin grant_vld = 1'b1; grant_idx = 1'b1;          end
      2'b11: begin grant_vld = 1'b1; grant_idx = ~last_grant_q; end
      default: begin grant_vld = 1'b0; grant_idx = 1'b0;        end
    endcase
  end

  always_comb begin
    sel_a  = bus.req_a[0 +: DATA_W];
    sel_b  = bus.req_b[0 +: DATA_W];
    sel_op = bus.req_op[0 +: OP_W];
    if (grant_idx) begin
      sel_a  = bus.req_a[DATA_W +: DATA_W];
      sel_b  = bus.req_b[DATA_W +: DATA_W];
      sel_op = bus.req_op[OP_W +: OP_W];
    end
  end

  // Gated by rst so ready is low while reset is held, even with valid high.
  assign bus.req_ready = (!rst && state_q == IDLE && grant_vld) ? (2'b01 << grant_idx) : 2'b00;

  assign alu_en = (state_q == EXEC);

  lab2_ALU u_alu (
    .en_i (alu_en),
    .a_i  (op_a_q),
    .b_i  (op_b_q),
    .op_i (op_code_q),
    .y_o  (alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= '0;
      result_q     <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_valid_q  <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            op_a_q       <= sel_a;
            op_b_q       <= sel_b;
            op_code_q    <= sel_op;
            owner_q      <= grant_idx;
            last_grant_q <= grant_idx;
            busy_q       <= 1'b1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          result_q    <= alu_y;
          rsp_zero_q  <= (alu_y == '0);
          rsp_valid_q <= 2'b01 << owner_q;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[owner_q]) begin
            rsp_valid_q <= 2'b00;
            rsp_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          rsp_zero_q  <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = result_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected results are queued on each grant and
// checked against the response that the arbiter later presents.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic       owner;
    logic [3:0] data;
    logic       zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic tb_last;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a;
    endcase
  endfunction

  function automatic logic pick(input logic [1:0] v, input logic last);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    return ~last;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op);
    bus.req_a[i*4 +: 4]  = a;
    bus.req_b[i*4 +: 4]  = b;
    bus.req_op[i*2 +: 2] = op;
  endtask

  task automatic accept(input string tag);
    logic       idx;
    int         ii;
    logic [3:0] y;
    exp_t       e;
    #1;
    idx = pick(bus.req_valid, tb_last);
    ii  = idx ? 1 : 0;
    chk(tag, {30'd0, bus.req_ready}, {30'd0, (2'b01 << idx)});
    y       = model(bus.req_a[ii*4 +: 4], bus.req_b[ii*4 +: 4], bus.req_op[ii*2 +: 2]);
    e.owner = idx;
    e.data  = y;
    e.zero  = (y == 4'h0);
    sb.push_back(e);
    tb_last = idx;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (bus.rsp_valid == 2'b00 && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 1);
    if (bus.rsp_valid != 2'b00) begin
      chk({tag, "_sb_nonempty"}, {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_vld"},  {30'd0, bus.rsp_valid}, {30'd0, (2'b01 << e.owner)});
        chk({tag, "_data"}, {28'd0, bus.rsp_data},  {28'd0, e.data});
        chk({tag, "_zero"}, {31'd0, bus.rsp_zero},  {31'd0, e.zero});
      end
    end
  endtask

  task automatic ack(input logic owner, input string tag);
    bus.rsp_ready = 2'b01 << owner;
    tick();
    bus.rsp_ready = 2'b00;
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_vld0"}, {30'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 2'b01;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 2'b00;
    tb_last       = 1'b1;

    #12;
    chk("rst_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_data", {28'd0, bus.rsp_data}, 32'd0);
    chk("rst_zero", {31'd0, bus.rsp_zero}, 32'd0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_no_rsp", {30'd0, bus.rsp_valid}, 32'd0);
    end
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);

    // contention: both held valid across completions, grants alternate 0,1,0
    set_req(0, 4'h2, 4'h7, OP_SUB);
    set_req(1, 4'hC, 4'hA, OP_AND);
    bus.req_valid = 2'b11;
    accept("c0_ready");
    chk("c0_exec_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("c0_exec_busy", {31'd0, bus.busy}, 32'd1);
    wait_rsp("c0");
    chk("c0_resp_ready", {30'd0, bus.req_ready}, 32'd0);
    ack(1'b0, "c0_ack");
    accept("c1_ready");
    wait_rsp("c1");
    ack(1'b1, "c1_ack");
    accept("c2_ready");
    bus.req_valid = 2'b00;
    wait_rsp("c2");
    ack(1'b0, "c2_ack");

    // single request with held response; non-owner ready must be ignored
    set_req(0, 4'h3, 4'h5, OP_ADD);
    bus.req_valid = 2'b01;
    accept("s0_ready");
    bus.req_valid = 2'b00;
    wait_rsp("s0");
    bus.rsp_ready = 2'b10;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_data", {28'd0, bus.rsp_data}, 32'd8);
      chk("hold_valid", {30'd0, bus.rsp_valid}, 32'd1);
      chk("hold_zero", {31'd0, bus.rsp_zero}, 32'd0);
    end
    bus.rsp_ready = 2'b00;
    ack(1'b0, "s0_ack");

    set_req(1, 4'hF, 4'h1, OP_ADD);
    bus.req_valid = 2'b10;
    accept("wrap_ready");
    bus.req_valid = 2'b00;
    wait_rsp("wrap");
    ack(1'b1, "wrap_ack");

    set_req(0, 4'h9, 4'h4, OP_PASSA);
    bus.req_valid = 2'b01;
    accept("passa_ready");
    bus.req_valid = 2'b00;
    wait_rsp("passa");
    ack(1'b0, "passa_ack");

    set_req(0, 4'h0, 4'h1, OP_SUB);
    bus.req_valid = 2'b01;
    accept("borrow_ready");
    bus.req_valid = 2'b00;
    wait_rsp("borrow");
    ack(1'b0, "borrow_ack");

    // reset asserted mid-cycle during EXEC discards the operation
    set_req(1, 4'h1, 4'h1, OP_ADD);
    bus.req_valid = 2'b10;
    accept("mid_ready");
    chk("mid_exec_busy", {31'd0, bus.busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("mid_rst_valid", {30'd0, bus.rsp_valid}, 32'd0);
    sb.delete();
    tb_last = 1'b1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_no_rsp", {30'd0, bus.rsp_valid}, 32'd0);
    end

    set_req(0, 4'h6, 4'h6, OP_SUB);
    set_req(1, 4'h5, 4'h3, OP_ADD);
    bus.req_valid = 2'b11;
    accept("post_rst_ready");
    bus.req_valid = 2'b00;
    wait_rsp("post_rst");
    ack(1'b0, "post_rst_ack");

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one 4-bit ALU (lab2_ALU) between two requesters using round-robin arbitration. Each requester issues operations over a valid/ready request channel and receives its result over a valid/ready response channel. The controller registers the operands, drives the ALU for one cycle, then holds the result until the owning requester accepts it. It sits between the requesters and the single shared ALU instance.

Parameters:
DATA_W, 4, operand/result width; fixed at 4 to match lab2_ALU; any other value is a configuration error.
OP_W, 2, opcode width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req_valid  input  2  bit i: requester i presents an operation
req_ready  output  2  bit i: request i accepted this cycle (one-hot or zero)
req_a  input  2*DATA_W  operand A per requester; requester i uses bits [i*4 +: 4]
req_b  input  2*DATA_W  operand B per requester; same packing as req_a
req_op  input  2*OP_W  opcode per requester; 00 add, 01 sub, 10 and, 11 pass A
rsp_valid  output  2  bit i: result for requester i is available
rsp_ready  input  2  bit i: requester i accepts its result
rsp_data  output  DATA_W  result; valid only while rsp_valid is non-zero
rsp_zero  output  1  rsp_data == 0; qualified by rsp_valid
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst is high, every output is 0, including the combinational req_ready.
- Reset state: state=IDLE, owner=0, last_grant=1 (so requester 0 wins the first contention), op_a/op_b/op_code=0, result=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant selection:
    - If exactly one req_valid bit is set, that requester is granted.
    - If both bits are set, the requester other than last_grant is granted.
    - If neither bit is set, no grant.
  - req_ready is combinational and asserted only for the granted requester.
  - On a handshake (valid and ready): latch that requester's A, B and op; owner <= granted index; last_grant <= granted index; go to EXEC.
- EXEC:
  - ALU enable=1 with the latched operands.
  - result <= ALU out at the clock edge; go to RESP.
  - Outside EXEC, ALU enable=0.
- RESP:
  - rsp_valid[owner]=1; rsp_data=result; rsp_zero=(result==0).
  - rsp_data and rsp_zero stay stable until rsp_ready[owner]=1; on that edge go to IDLE.
  - rsp_ready of the non-owner is ignored.
- Latency and throughput:
  - Request accepted at edge N; rsp_valid is high in the cycle after edge N+1.
  - Minimum 3 cycles per operation; at most one operation in flight; no back-to-back acceptance.
- Arithmetic: modulo 16, no carry or borrow output. 0xF+0x1=0x0. 0x0-0x1=0xF.
- Simultaneous events:
  - A new req_valid during EXEC or RESP is not accepted; req_ready stays 0.
  - A requester may keep req_valid high while its own response is pending; it is arbitrated normally once the FSM returns to IDLE.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...
- Reset mid-operation: the in-flight operation is discarded, no response is issued, and the FSM returns to IDLE immediately (asynchronously).
- Illegal opcode: none exists; all four encodings are defined.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_PASSA=2'b11;
  - state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - DATA_W=4.
- One sub-module: lab2_ALU, instantiated once; the controller drives its enable, A, B and opcode.
- The round-robin select is small enough to stay inline; no separate arbiter module.

Test Plan:
- Reset state: assert rst mid-cycle -> all outputs 0 immediately; after release, busy=0 and no response appears.
- Single request: req_valid=01, A=3, B=5, op=00 -> req_ready=01 in that cycle; rsp_valid=01 with rsp_data=8 and rsp_zero=0 two edges later; data held 3 cycles while rsp_ready=0.
- Contention and alternation: both valid; r0 A=2,B=7,op=01 and r1 A=0xC,B=0xA,op=10, each held valid after completion -> r0 served first with 0xB, then r1 with 0x8 and rsp_zero=0, then r0 again.
- Wrap and zero flag: A=0xF, B=0x1, op=00 -> rsp_data=0, rsp_zero=1; A=0x9, op=11 -> rsp_data=0x9.
- Reset mid-operation: accept a request, assert rst during EXEC -> no rsp_valid ever appears for it; the next request after reset is granted to r0 on contention.
